regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised register file for the multicycle datapath. Two write ports: port A for ALU writeback and port B for load writeback. Two asynchronous read ports with optional write-to-read bypass. A per-register busy scoreboard lets the controller stall on operands whose load has not yet written back.

Parameters:
DATA_W, 32, data width of every register and write/read data port
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy
BYPASS, 1, 1 = a read of an address being written this cycle returns the write data

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ra1  input  ADDR_W  read address 1
ra2  input  ADDR_W  read address 2
rd1  output  DATA_W  read data 1 (combinational)
rd2  output  DATA_W  read data 2 (combinational)
we_a  input  1  write enable, port A (ALU)
wa_a  input  ADDR_W  write address, port A
wd_a  input  DATA_W  write data, port A
we_b  input  1  write enable, port B (load writeback)
wa_b  input  ADDR_W  write address, port B
wd_b  input  DATA_W  write data, port B
mark  input  1  set busy bit of mark_addr (load issued)
mark_addr  input  ADDR_W  register to mark busy
busy1  output  1  busy bit of ra1 (registered state, combinational select)
busy2  output  1  busy bit of ra2
busy_cnt  output  ADDR_W+1  number of registers currently busy (registered)
wr_conflict  output  1  one-cycle registered pulse: both ports wrote the same address

Behaviour:
- Reset (rst_n low, async): all DEPTH registers = 0, all busy bits = 0, busy_cnt = 0, wr_conflict = 0. rd1/rd2 therefore read 0. Release is synchronous to the next clk edge.
- Write: on posedge, if we_a then RF[wa_a] <= wd_a; if we_b then RF[wa_b] <= wd_b. One-cycle write latency.
- Same-address dual write (we_a & we_b & wa_a==wa_b): port A data is stored and wr_conflict = 1 for the following cycle, otherwise 0. With ZERO_REG=1, a conflict on address 0 still pulses wr_conflict.
- ZERO_REG=1: writes to address 0 are discarded, rd returns 0 for address 0 regardless of bypass, busy1/busy2 = 0 for address 0, and mark to address 0 is ignored.
- Read, combinational: rd = RF[ra].
- Read with BYPASS=1: if we_a & wa_a==ra, rd = wd_a; else if we_b & wa_b==ra, rd = wd_b; else rd = RF[ra].
- Read with BYPASS=0: old contents are returned until the edge.
- Scoreboard, per register r, next busy[r]:
  - mark & mark_addr==r → 1 (mark wins over a same-cycle clear)
  - else we_b & wa_b==r → 0
  - else unchanged
- Port A writes never change busy bits.
- Marking an already-busy register keeps it busy; busy_cnt is not double-counted.
- Port B write to a non-busy register is legal: data is written, busy stays 0.
- busy_cnt is the registered population count of the busy bits, updated on the same edge as the bits. Range 0..DEPTH (DEPTH-1 when ZERO_REG=1).
- busy1/busy2 reflect registered busy state only; they are not bypassed by a same-cycle port B write.
- Reset asserted mid-operation clears data and scoreboard immediately; any in-flight writes that cycle are lost.

Test Plan:
1. Reset, then read ra1=3, ra2=31 → rd1=0, rd2=0, busy1=busy2=0, busy_cnt=0.
2. we_a=1, wa_a=5, wd_a=0xDEADBEEF with ra1=5:
   - BYPASS=1 → rd1=0xDEADBEEF in the same cycle.
   - BYPASS=0 → rd1=0 that cycle and 0xDEADBEEF the next.
3. Write 0x1234 to register 0 via both ports, then read ra1=0:
   - ZERO_REG=1 → rd1=0.
   - ZERO_REG=0 → rd1=0x1234 (port A value), wr_conflict=1 for exactly one cycle.
4. Scoreboard clear:
   - mark with mark_addr=7, then ra1=7 → busy1=1, busy_cnt=1.
   - Next cycle, we_b=1, wa_b=7, wd_b=0xAA → busy1=0, busy_cnt=0, rd1=0xAA.
5. Scoreboard mark-wins: with register 9 busy, assert mark to 9 and we_b to 9 (0x55) in the same cycle → RF[9]=0x55, busy stays 1, busy_cnt unchanged.
6. Reset mid-operation:
   - Write 0x10 to 4 and mark 4 and 6 (busy_cnt=2).
   - Drop rst_n mid-cycle → rd of 4 = 0 and busy_cnt = 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/regfile_sb.sv
// Two-write, two-read register file with load-busy scoreboard for the multicycle datapath.
// Port A has priority over port B on a same-address write; optional zero register and write bypass.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_b,
  input  logic              mark,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wen_a;
  logic              wen_b;

  assign wen_a = we_a && !((ZERO_REG != 0) && (wa_a == '0));
  assign wen_b = we_b && !((ZERO_REG != 0) && (wa_b == '0));

  // Port B is applied first so port A overwrites it on a same-address write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      if (wen_b) rf[wa_b] <= wd_b;
      if (wen_a) rf[wa_a] <= wd_a;
    end
  end

  // Mark is applied last so it wins over a same-cycle load writeback clear.
  always_comb begin
    busy_nxt = busy;
    if (we_b) busy_nxt[wa_b] = 1'b0;
    if (mark) busy_nxt[mark_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      busy_cnt    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      busy        <= busy_nxt;
      busy_cnt    <= cnt_nxt;
      wr_conflict <= we_a && we_b && (wa_a == wa_b);
    end
  end

  always_comb begin
    rd1 = rf[ra1];
    if (BYPASS != 0) begin
      if (we_a && (wa_a == ra1))      rd1 = wd_a;
      else if (we_b && (wa_b == ra1)) rd1 = wd_b;
    end
    if ((ZERO_REG != 0) && (ra1 == '0)) rd1 = '0;
  end

  always_comb begin
    rd2 = rf[ra2];
    if (BYPASS != 0) begin
      if (we_a && (wa_a == ra2))      rd2 = wd_a;
      else if (we_b && (wa_b == ra2)) rd2 = wd_b;
    end
    if ((ZERO_REG != 0) && (ra2 == '0)) rd2 = '0;
  end

  assign busy1 = busy[ra1];
  assign busy2 = busy[ra2];

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: one instance with defaults, one with ZERO_REG=0/BYPASS=0.
// Stimulus pushes expected values; the negedge monitor pops and compares them.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa_a, wa_b, mark_addr;
  logic [31:0] wd_a, wd_b;
  logic        we_a, we_b, mark;

  logic [31:0] rd1, rd2, rd1_n, rd2_n;
  logic        busy1, busy2, wr_conflict, busy1_n, busy2_n, wr_conflict_n;
  logic [5:0]  busy_cnt, busy_cnt_n;

  localparam int F_RD1 = 0, F_RD2 = 1, F_B1 = 2, F_B2 = 3, F_CNT = 4, F_CONF = 5;
  localparam int N = 8;  // field offset for the no-zero/no-bypass instance

  typedef struct {
    string       name;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .mark(mark), .mark_addr(mark_addr), .busy1(busy1), .busy2(busy2),
    .busy_cnt(busy_cnt), .wr_conflict(wr_conflict)
  );

  regfile_sb #(.ZERO_REG(0), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .mark(mark), .mark_addr(mark_addr), .busy1(busy1_n), .busy2(busy2_n),
    .busy_cnt(busy_cnt_n), .wr_conflict(wr_conflict_n)
  );

  function automatic logic [31:0] actual(int f);
    case (f)
      F_RD1:      return rd1;
      F_RD2:      return rd2;
      F_B1:       return {31'b0, busy1};
      F_B2:       return {31'b0, busy2};
      F_CNT:      return {26'b0, busy_cnt};
      F_CONF:     return {31'b0, wr_conflict};
      N + F_RD1:  return rd1_n;
      N + F_RD2:  return rd2_n;
      N + F_B1:   return {31'b0, busy1_n};
      N + F_B2:   return {31'b0, busy2_n};
      N + F_CNT:  return {26'b0, busy_cnt_n};
      N + F_CONF: return {31'b0, wr_conflict_n};
      default:    return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: outputs are combinational/registered, sampled mid-cycle on negedge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.fld);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
      end
    end
  end

  task automatic exp_push(input string n, input int f, input logic [31:0] v);
    q.push_back('{n, f, v});
  endtask

  task automatic idle();
    we_a = 0; wa_a = 0; wd_a = 0;
    we_b = 0; wa_b = 0; wd_b = 0;
    mark = 0; mark_addr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; idle(); ra1 = 0; ra2 = 0;
    step();
    exp_push("rst_cnt", F_CNT, 0);
    exp_push("rst_rd1_n", N + F_RD1, 0);
    step();
    rst_n = 1;

    // 1: reset contents
    ra1 = 3; ra2 = 31;
    exp_push("t1_rd1", F_RD1, 0);
    exp_push("t1_rd2", F_RD2, 0);
    exp_push("t1_busy1", F_B1, 0);
    exp_push("t1_busy2", F_B2, 0);
    exp_push("t1_cnt", F_CNT, 0);
    exp_push("t1_conf", F_CONF, 0);
    step();

    // 2: port A write with and without bypass
    we_a = 1; wa_a = 5; wd_a = 32'hDEADBEEF; ra1 = 5;
    exp_push("t2_bypass_rd1", F_RD1, 32'hDEADBEEF);
    exp_push("t2_nobypass_rd1", N + F_RD1, 0);
    step();
    idle();
    exp_push("t2_after_rd1", F_RD1, 32'hDEADBEEF);
    exp_push("t2_after_rd1_n", N + F_RD1, 32'hDEADBEEF);
    step();

    // 3: dual write to register 0, port A wins
    we_a = 1; wa_a = 0; wd_a = 32'h1234;
    we_b = 1; wa_b = 0; wd_b = 32'h5678; ra1 = 0;
    exp_push("t3_zero_rd1", F_RD1, 0);
    exp_push("t3_old_rd1_n", N + F_RD1, 0);
    exp_push("t3_conf_pre", F_CONF, 0);
    step();
    idle();
    exp_push("t3_zero_after", F_RD1, 0);
    exp_push("t3_porta_rd1_n", N + F_RD1, 32'h1234);
    exp_push("t3_conf", F_CONF, 1);
    exp_push("t3_conf_n", N + F_CONF, 1);
    step();
    exp_push("t3_conf_drop", F_CONF, 0);
    exp_push("t3_conf_drop_n", N + F_CONF, 0);

    // mark to register 0 is ignored only with the zero register
    mark = 1; mark_addr = 0;
    step();
    idle(); we_b = 1; wa_b = 0; wd_b = 0;
    exp_push("z_busy1", F_B1, 0);
    exp_push("z_cnt", F_CNT, 0);
    exp_push("z_busy1_n", N + F_B1, 1);
    exp_push("z_cnt_n", N + F_CNT, 1);
    step();
    idle();
    exp_push("z_clr_cnt_n", N + F_CNT, 0);
    step();

    // 4: mark then clear via load writeback
    mark = 1; mark_addr = 7; ra1 = 7; ra2 = 7;
    exp_push("t4_busy1_pre", F_B1, 0);
    step();
    idle(); we_b = 1; wa_b = 7; wd_b = 32'hAA;
    exp_push("t4_busy1", F_B1, 1);
    exp_push("t4_busy2", F_B2, 1);
    exp_push("t4_cnt", F_CNT, 1);
    exp_push("t4_bypass_rd2", F_RD2, 32'hAA);
    exp_push("t4_nobypass_rd1_n", N + F_RD1, 0);
    step();
    idle();
    exp_push("t4_clr_busy1", F_B1, 0);
    exp_push("t4_clr_cnt", F_CNT, 0);
    exp_push("t4_rd1", F_RD1, 32'hAA);
    exp_push("t4_rd1_n", N + F_RD1, 32'hAA);
    step();

    // 5: mark wins over same-cycle clear
    mark = 1; mark_addr = 9;
    step();
    mark = 1; mark_addr = 9; we_b = 1; wa_b = 9; wd_b = 32'h55; ra1 = 9; ra2 = 9;
    exp_push("t5_busy1_pre", F_B1, 1);
    exp_push("t5_cnt_pre", F_CNT, 1);
    step();
    idle();
    exp_push("t5_rd1", F_RD1, 32'h55);
    exp_push("t5_busy1", F_B1, 1);
    exp_push("t5_busy2_n", N + F_B2, 1);
    exp_push("t5_cnt", F_CNT, 1);
    step();

    // 6: reset mid-operation
    we_a = 1; wa_a = 4; wd_a = 32'h10; mark = 1; mark_addr = 4;
    we_b = 1; wa_b = 9; wd_b = 32'h55;
    step();
    idle(); mark = 1; mark_addr = 6;
    step();
    idle(); ra1 = 4; ra2 = 6;
    exp_push("t6_rd1", F_RD1, 32'h10);
    exp_push("t6_busy1", F_B1, 1);
    exp_push("t6_busy2", F_B2, 1);
    exp_push("t6_cnt", F_CNT, 2);
    exp_push("t6_cnt_n", N + F_CNT, 2);
    step();
    #1;
    rst_n = 0; we_a = 1; wa_a = 8; wd_a = 32'h77;
    exp_push("t6_rst_rd1", F_RD1, 0);
    exp_push("t6_rst_busy1", F_B1, 0);
    exp_push("t6_rst_busy2", F_B2, 0);
    exp_push("t6_rst_cnt", F_CNT, 0);
    exp_push("t6_rst_rd1_n", N + F_RD1, 0);
    exp_push("t6_rst_cnt_n", N + F_CNT, 0);
    step();
    rst_n = 1; idle(); ra1 = 8;
    exp_push("t6_lost_write", F_RD1, 0);
    exp_push("t6_lost_write_n", N + F_RD1, 0);
    step();
    step();

    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
